// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one 8-bit ALU between NUM_REQ requesters.
// One op in flight at a time; responses carry the owning requester's ID.
module alu_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]  req_op_a,
    input  logic [NUM_REQ*DATA_W-1:0]  req_op_b,
    input  logic [NUM_REQ*3-1:0]       req_alu_op,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [DATA_W-1:0]          rsp_result,
    output logic                       rsp_err,
    output logic                       busy
);
    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
    logic                rsp_err_q, rsp_err_d;

    logic [DATA_W-1:0]   cap_a_q, cap_b_q;
    logic [2:0]          cap_op_q;
    logic [ID_W-1:0]     cap_id_q;

    logic [ID_W-1:0]     winner;
    logic                any_valid;
    logic [ID_W:0]       cand;
    logic [ID_W:0]       ptr_inc;
    logic [ID_W-1:0]     nxt_ptr;
    logic                grant;
    logic [DATA_W-1:0]   sel_a, sel_b;
    logic [2:0]          sel_op;

    // Returns {err, result}; illegal codes give a zero result with err set.
    function automatic logic [DATA_W:0] alu_eval(input logic [2:0] op,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] r;
        logic              err;
        r   = '0;
        err = 1'b0;
        case (op)
            3'b000:  r = a + b;
            3'b001:  r = a - b;
            3'b010:  r = a & b;
            3'b011:  r = a | b;
            3'b100:  r = a ^ b;
            3'b101:  r = ~a;
            default: err = 1'b1;
        endcase
        return {err, r};
    endfunction

    // Search starts at rr_ptr and wraps; first valid requester wins.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!any_valid && req_valid[cand[ID_W-1:0]]) begin
                any_valid = 1'b1;
                winner    = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == ID_W'(i)) begin
                sel_a  = req_op_a[i*DATA_W +: DATA_W];
                sel_b  = req_op_b[i*DATA_W +: DATA_W];
                sel_op = req_alu_op[i*3 +: 3];
            end
        end
    end

    assign grant   = (state_q == IDLE) && any_valid;
    assign ptr_inc = {1'b0, winner} + (ID_W+1)'(1);
    assign nxt_ptr = (ptr_inc == (ID_W+1)'(NUM_REQ)) ? '0 : ptr_inc[ID_W-1:0];

    // Gated by rst_n so the grant vector is quiet while reset is asserted.
    always_comb begin
        req_ready = '0;
        if (grant && rst_n) begin
            req_ready[winner] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    state_d  = EXEC;
                    rr_ptr_d = nxt_ptr;
                end
            end
            EXEC: begin
                {rsp_err_d, rsp_result_d} = alu_eval(cap_op_q, cap_a_q, cap_b_q);
                rsp_id_d = cap_id_q;
                state_d  = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    // Operand capture needs no reset: it is only consumed after a grant loads it.
    always_ff @(posedge clk) begin
        if (grant) begin
            cap_a_q  <= sel_a;
            cap_b_q  <= sel_b;
            cap_op_q <= sel_op;
            cap_id_q <= winner;
        end
    end

    assign rsp_valid  = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_err    = rsp_err_q;

endmodule
